// File: rtl/brick_array_ctrl.sv
// brick_array_ctrl
// Brick-field storage and bookkeeping for the breakout playfield.
// A fill sweep rebuilds the whole array from a pattern code. After the sweep,
// the scanner gets registered single-bit reads. Collision clears are queued in
// a one-entry buffer and retire in cycles where the scanner is idle.
module brick_array_ctrl #(
    parameter int BRICKS_H = 16,
    parameter int BRICKS_V = 8,
    parameter int N        = BRICKS_H * BRICKS_V,
    parameter int IDX_W    = 7
) (
    input  logic             visible_clk,
    input  logic             reset,
    input  logic             fill_req,
    input  logic [1:0]       fill_pattern,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_index,
    output logic             rd_data,
    input  logic             clr_req,
    input  logic [IDX_W-1:0] clr_index,
    output logic             clr_drop,
    output logic             incscore,
    output logic             busy,
    output logic [IDX_W:0]   brick_count,
    output logic             level_clear
);

    localparam logic [0:0]       FILL     = 1'b0;
    localparam logic [0:0]       RUN      = 1'b1;
    localparam logic [IDX_W:0]   N_CNT    = (IDX_W + 1)'(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    logic [0:0]       state;
    logic [IDX_W-1:0] fill_ptr;
    logic [1:0]       pattern;
    logic [N-1:0]     cells;

    logic             pend_valid;
    logic [IDX_W-1:0] pend_idx;

    logic             pat_bit;
    logic             in_run;
    logic             do_read;
    logic             do_exec;
    logic             exec_hit;
    logic             same_idx;
    logic             can_take;
    logic             take_clr;
    logic             drop_clr;

    // Pattern bit for the cell currently addressed by the fill sweep
    always_comb begin
        pat_bit = 1'b0;
        case (pattern)
            2'd0:    pat_bit = 1'b1;
            2'd1:    pat_bit = fill_ptr[0] ^ fill_ptr[4];
            2'd2:    pat_bit = ~fill_ptr[4];
            default: pat_bit = 1'b0;
        endcase
    end

    // Arbitration between scanner reads, pending-clear retirement and new clears.
    // A clear may enter the buffer in the same cycle the old entry retires.
    always_comb begin
        in_run   = (state == RUN);
        do_read  = in_run && rd_en;
        do_exec  = in_run && !rd_en && pend_valid;
        exec_hit = cells[pend_idx];
        same_idx = pend_valid && (clr_index == pend_idx);
        can_take = !pend_valid || do_exec;
        take_clr = in_run && clr_req && can_take && !same_idx;
        drop_clr = in_run && clr_req && !take_clr;
    end

    // Brick cells: no reset, rebuilt by the sweep; one indexed write per clock
    always_ff @(posedge visible_clk) begin
        if (!fill_req) begin
            if (state == FILL) begin
                cells[fill_ptr] <= pat_bit;
            end else if (do_exec) begin
                cells[pend_idx] <= 1'b0;
            end
        end
    end

    // Sweep state: FILL/RUN, fill pointer and latched pattern code
    always_ff @(posedge visible_clk or posedge reset) begin
        if (reset) begin
            state    <= FILL;
            fill_ptr <= '0;
            pattern  <= '0;
        end else if (fill_req) begin
            state    <= FILL;
            fill_ptr <= '0;
            pattern  <= fill_pattern;
        end else if (state == FILL) begin
            fill_ptr <= fill_ptr + 1'b1;
            if (fill_ptr == LAST_IDX) begin
                state <= RUN;
            end
        end
    end

    // Brick population counter, saturating at both ends
    always_ff @(posedge visible_clk or posedge reset) begin
        if (reset) begin
            brick_count <= '0;
        end else if (fill_req) begin
            brick_count <= '0;
        end else if (state == FILL) begin
            if (pat_bit && (brick_count != N_CNT)) begin
                brick_count <= brick_count + 1'b1;
            end
        end else if (do_exec && exec_hit && (brick_count != '0)) begin
            brick_count <= brick_count - 1'b1;
        end
    end

    // One-entry pending clear buffer
    always_ff @(posedge visible_clk or posedge reset) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_idx   <= '0;
        end else if (fill_req) begin
            pend_valid <= 1'b0;
        end else if (take_clr) begin
            pend_valid <= 1'b1;
            pend_idx   <= clr_index;
        end else if (do_exec) begin
            pend_valid <= 1'b0;
        end
    end

    // Registered scanner read; forced low during the sweep, held when idle
    always_ff @(posedge visible_clk or posedge reset) begin
        if (reset) begin
            rd_data <= 1'b0;
        end else if (fill_req || (state == FILL)) begin
            rd_data <= 1'b0;
        end else if (do_read) begin
            rd_data <= cells[rd_index];
        end
    end

    // Single-cycle event pulses for the score logic and clear-drop reporting
    always_ff @(posedge visible_clk or posedge reset) begin
        if (reset) begin
            incscore <= 1'b0;
            clr_drop <= 1'b0;
        end else if (fill_req) begin
            incscore <= 1'b0;
            clr_drop <= 1'b0;
        end else begin
            incscore <= do_exec && exec_hit;
            clr_drop <= drop_clr;
        end
    end

    assign busy        = (state == FILL);
    assign level_clear = (state == RUN) && (brick_count == '0);

endmodule

// File: tb/tb_brick_array_ctrl.sv
// tb_brick_array_ctrl
// Directed checks of fill sweep, patterns, reads, clear queueing and reset.
module tb_brick_array_ctrl;

    localparam int IDX_W = 7;

    logic             visible_clk;
    logic             reset;
    logic             fill_req;
    logic [1:0]       fill_pattern;
    logic             rd_en;
    logic [IDX_W-1:0] rd_index;
    logic             rd_data;
    logic             clr_req;
    logic [IDX_W-1:0] clr_index;
    logic             clr_drop;
    logic             incscore;
    logic             busy;
    logic [IDX_W:0]   brick_count;
    logic             level_clear;

    int n_checks = 0;
    int n_pass   = 0;
    int inc_seen;
    int drop_seen;

    brick_array_ctrl #(
        .BRICKS_H (16),
        .BRICKS_V (8),
        .IDX_W    (IDX_W)
    ) dut (
        .visible_clk  (visible_clk),
        .reset        (reset),
        .fill_req     (fill_req),
        .fill_pattern (fill_pattern),
        .rd_en        (rd_en),
        .rd_index     (rd_index),
        .rd_data      (rd_data),
        .clr_req      (clr_req),
        .clr_index    (clr_index),
        .clr_drop     (clr_drop),
        .incscore     (incscore),
        .busy         (busy),
        .brick_count  (brick_count),
        .level_clear  (level_clear)
    );

    initial visible_clk = 1'b0;
    always #5 visible_clk = ~visible_clk;

    // Count one comparison and report it if it disagrees
    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance to just after the next active edge
    task automatic tick();
        @(posedge visible_clk);
        #1;
    endtask

    // Advance one edge while tallying pulse outputs
    task automatic tick_mon();
        tick();
        inc_seen  += int'(incscore);
        drop_seen += int'(clr_drop);
    endtask

    task automatic do_fill(input logic [1:0] pat);
        fill_req     = 1'b1;
        fill_pattern = pat;
        tick();
        fill_req = 1'b0;
        repeat (128) tick();
    endtask

    task automatic read_chk(input string tag, input int idx, input int exp);
        rd_en    = 1'b1;
        rd_index = IDX_W'(idx);
        tick();
        rd_en = 1'b0;
        check_val(tag, int'(rd_data), exp);
    endtask

    initial begin
        reset        = 1'b1;
        fill_req     = 1'b0;
        fill_pattern = 2'd0;
        rd_en        = 1'b0;
        rd_index     = '0;
        clr_req      = 1'b0;
        clr_index    = '0;
        inc_seen     = 0;
        drop_seen    = 0;

        // Reset values
        #2;
        check_val("rst_busy",   int'(busy), 1);
        check_val("rst_count",  int'(brick_count), 0);
        check_val("rst_lclr",   int'(level_clear), 0);
        check_val("rst_rd",     int'(rd_data), 0);
        check_val("rst_inc",    int'(incscore), 0);
        check_val("rst_drop",   int'(clr_drop), 0);
        #10 reset = 1'b0;

        // Default sweep, pattern 0
        repeat (127) tick();
        check_val("p0_busy127", int'(busy), 1);
        check_val("p0_cnt127",  int'(brick_count), 127);
        tick();
        check_val("p0_busy",    int'(busy), 0);
        check_val("p0_count",   int'(brick_count), 128);
        check_val("p0_lclr",    int'(level_clear), 0);
        read_chk("p0_rd0",   0,   1);
        read_chk("p0_rd127", 127, 1);
        read_chk("p0_rd64",  64,  1);
        rd_index = 7'd3;
        tick();
        check_val("rd_hold", int'(rd_data), 1);

        // Checkerboard pattern
        fill_req = 1'b1; fill_pattern = 2'd1;
        tick();
        fill_req = 1'b0;
        check_val("p1_busy",  int'(busy), 1);
        check_val("p1_cnt0",  int'(brick_count), 0);
        check_val("p1_rdfill", int'(rd_data), 0);
        repeat (128) tick();
        check_val("p1_count", int'(brick_count), 64);
        read_chk("p1_rd0",  0,  0);
        read_chk("p1_rd1",  1,  1);
        read_chk("p1_rd16", 16, 1);
        read_chk("p1_rd17", 17, 0);

        // Alternate rows
        do_fill(2'd2);
        check_val("p2_count", int'(brick_count), 64);
        read_chk("p2_rd0",  0,  1);
        read_chk("p2_rd16", 16, 0);
        read_chk("p2_rd47", 47, 1);

        // Empty pattern, with a clear attempted during the sweep
        fill_req = 1'b1; fill_pattern = 2'd3;
        tick();
        fill_req = 1'b0;
        clr_req = 1'b1; clr_index = 7'd2;
        tick();
        clr_req = 1'b0;
        tick();
        check_val("fill_clr_nodrop", int'(clr_drop), 0);
        repeat (126) tick();
        check_val("p3_count", int'(brick_count), 0);
        check_val("p3_lclr",  int'(level_clear), 1);
        check_val("p3_busy",  int'(busy), 0);

        // Clear deferred behind three read cycles
        do_fill(2'd0);
        clr_req = 1'b1; clr_index = 7'd5;
        rd_en = 1'b1; rd_index = 7'd5;
        tick();
        clr_req = 1'b0;
        check_val("dly_rd1",  int'(rd_data), 1);
        check_val("dly_inc1", int'(incscore), 0);
        tick();
        check_val("dly_inc2", int'(incscore), 0);
        tick();
        check_val("dly_rd3",  int'(rd_data), 1);
        check_val("dly_inc3", int'(incscore), 0);
        check_val("dly_cnt3", int'(brick_count), 128);
        rd_en = 1'b0;
        tick();
        check_val("dly_inc",  int'(incscore), 1);
        check_val("dly_cnt",  int'(brick_count), 127);
        tick();
        check_val("dly_inc_off", int'(incscore), 0);
        read_chk("dly_rd5", 5, 0);

        // Repeat clear of an already removed brick
        clr_req = 1'b1; clr_index = 7'd5;
        tick();
        clr_req = 1'b0;
        tick();
        check_val("rep_inc", int'(incscore), 0);
        check_val("rep_cnt", int'(brick_count), 127);

        // Buffer full while reads hold it -> drop
        rd_en = 1'b1; rd_index = 7'd0;
        clr_req = 1'b1; clr_index = 7'd5;
        tick();
        clr_index = 7'd7;
        tick();
        check_val("full_drop", int'(clr_drop), 1);
        clr_req = 1'b0;
        tick();
        check_val("drop_pulse_end", int'(clr_drop), 0);
        rd_en = 1'b0;
        tick();
        tick();
        read_chk("drop_rd7", 7, 1);

        // Same index as pending entry -> drop
        rd_en = 1'b1;
        clr_req = 1'b1; clr_index = 7'd9;
        tick();
        tick();
        check_val("same_drop", int'(clr_drop), 1);
        clr_req = 1'b0; rd_en = 1'b0;
        tick();
        check_val("same_inc", int'(incscore), 1);
        check_val("same_cnt", int'(brick_count), 126);

        // Clear everything back-to-back
        do_fill(2'd0);
        inc_seen = 0; drop_seen = 0;
        for (int i = 0; i < 128; i++) begin
            clr_req = 1'b1; clr_index = IDX_W'(i);
            tick_mon();
        end
        clr_req = 1'b0;
        tick_mon();
        check_val("all_inc",   inc_seen, 128);
        check_val("all_drop",  drop_seen, 0);
        check_val("all_count", int'(brick_count), 0);
        check_val("all_lclr",  int'(level_clear), 1);
        inc_seen = 0;
        clr_req = 1'b1; clr_index = 7'd3;
        tick_mon();
        clr_req = 1'b0;
        tick_mon();
        tick_mon();
        check_val("sat_inc",   inc_seen, 0);
        check_val("sat_count", int'(brick_count), 0);

        // Refill with a clear pending, then reset mid-sweep
        inc_seen = 0; drop_seen = 0;
        rd_en = 1'b1; rd_index = 7'd0;
        clr_req = 1'b1; clr_index = 7'd10;
        tick_mon();
        clr_req = 1'b0; rd_en = 1'b0;
        fill_req = 1'b1; fill_pattern = 2'd0;
        tick_mon();
        fill_req = 1'b0;
        check_val("rf_busy", int'(busy), 1);
        check_val("rf_cnt",  int'(brick_count), 0);
        repeat (20) tick_mon();
        check_val("rf_cnt20", int'(brick_count), 20);
        check_val("rf_inc",   inc_seen, 0);
        check_val("rf_drop",  drop_seen, 0);
        reset = 1'b1;
        #2;
        check_val("mr_busy", int'(busy), 1);
        check_val("mr_cnt",  int'(brick_count), 0);
        reset = 1'b0;
        repeat (127) tick_mon();
        check_val("mr_busy127", int'(busy), 1);
        tick_mon();
        check_val("mr_busy_end", int'(busy), 0);
        check_val("mr_count",    int'(brick_count), 128);
        check_val("mr_inc",      inc_seen, 0);
        check_val("mr_drop",     drop_seen, 0);
        read_chk("mr_rd10", 10, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/brick_array_ctrl.md
BRICK_ARRAY_CTRL -- requirements
Module: brick_array_ctrl

Interface
REQ-001 SHALL have parameters: BRICKS_H, default 16, bricks per row; BRICKS_V, default 8, brick rows; N = BRICKS_H*BRICKS_V (128), array size; IDX_W, default 7, index width.
REQ-002 SHALL have ports:
- visible_clk  in  1  clock; ticks only during display_on.
- reset  in  1  asynchronous, active-high.
- fill_req  in  1  start level fill, sampled per clock.
- fill_pattern  in  2  pattern code, sampled with fill_req.
- rd_en  in  1  scanner read request.
- rd_index  in  IDX_W  scanner read index.
- rd_data  out  1  brick bit for the previous cycle's read.
- clr_req  in  1  collision clear request.
- clr_index  in  IDX_W  index to clear.
- clr_drop  out  1  one-cycle pulse when a clear request is discarded.
- incscore  out  1  one-cycle pulse per brick actually removed.
- busy  out  1  high while FILL is active.
- brick_count  out  IDX_W+1  bricks present, 0..N.
- level_clear  out  1  high in RUN when brick_count == 0.

Function
REQ-003 SHALL hold N one-bit brick cells in flops, with no reset on the array itself, and perform one indexed access per clock.
REQ-004 SHALL implement states FILL and RUN; reset enters FILL with fill_ptr=0 and pattern=0.
REQ-005 In FILL, SHALL write cell[fill_ptr] from the pattern, then increment fill_ptr each clock; brick_count SHALL increment on each written 1.
REQ-006 Pattern bit for index i: 0 -> 1; 1 -> i[0]^i[4] (checkerboard); 2 -> ~i[4] (alternate rows); 3 -> 0.
REQ-007 After writing index N-1, SHALL enter RUN on the next clock; busy = (state==FILL).
REQ-008 fill_req in any state SHALL restart FILL on the next clock: fill_ptr=0, brick_count=0, pattern latched, pending clear discarded without a clr_drop pulse.
REQ-009 In FILL, rd_data SHALL return 0 and clr_req SHALL be ignored (no capture, no clr_drop).
REQ-010 In RUN, rd_en SHALL have priority: rd_data <= cell[rd_index], registered, 1-cycle latency; rd_data holds its value when rd_en=0.
REQ-011 Clears SHALL go through a 1-entry pending buffer (valid + index); clr_req is captured when the buffer is empty or is being freed in the same cycle.
REQ-012 A pending clear SHALL execute in the first RUN cycle with rd_en=0; it reads and then zeroes the cell in the same cycle, and frees the buffer.
REQ-013 If the executed cell was 1, SHALL pulse incscore the next cycle and decrement brick_count on the same edge; if it was 0, SHALL leave incscore and brick_count unchanged.
REQ-014 clr_req arriving while the buffer is full and not freeing SHALL be dropped with a clr_drop pulse the next cycle; a clear to the same index as the pending entry SHALL also be dropped with a clr_drop pulse.
REQ-015 Same-cycle rd_en and pending-clear execution on the same index cannot occur (reads win); a read SHALL return the pre-clear value until the clear executes.
REQ-016 brick_count SHALL never wrap: it saturates at 0 and cannot exceed N.
REQ-017 level_clear SHALL be decoded from registers only: (state==RUN) && (brick_count==0).
REQ-018 fill_req takes precedence over rd_en and clr_req in the same cycle.

Reset
REQ-019 Asynchronous reset SHALL set: state=FILL, fill_ptr=0, pattern=0, brick_count=0, pending invalid, rd_data=0, incscore=0, clr_drop=0.
REQ-020 After reset, busy=1 and level_clear=0; array contents SHALL be rebuilt entirely by the fill sweep.
REQ-021 Reset asserted mid-FILL or mid-clear SHALL abort the operation; the sweep restarts from index 0.

Verification
REQ-022 Reset, 128 clocks with no requests -> busy falls after index 127, brick_count=128, then rd of any index returns 1.
REQ-023 fill_req with pattern 1 -> brick_count=64, rd_index 0 -> 0, 1 -> 1, 16 -> 1; pattern 3 -> brick_count=0, level_clear=1.
REQ-024 RUN, clr_req idx 5 with rd_en=1 held 3 cycles -> no incscore until the first rd_en=0 cycle, then incscore pulse, count 127, rd idx 5 -> 0.
REQ-025 clr_req idx 5 twice (second after removal) -> one incscore only; idx 7 while idx 5 pending and rd_en=1 -> clr_drop pulse.
REQ-026 Clear all 128 under pattern 0 -> brick_count reaches 0, level_clear=1; a further clear -> count stays 0, no incscore.
REQ-027 fill_req while a clear is pending, then reset mid-sweep -> no incscore, no clr_drop, sweep restarts at 0, busy=1.
